// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
//   Sequential packed-BCD to binary converter (reverse double-dabble).
//   Each iteration shifts {bcd, bin} right by one bit, then subtracts 3 from
//   every BCD digit that ended up >= 8. After BIN_W iterations the binary
//   register holds the value of the captured operand.
//
// Ports
//   clk       rising-edge system clock
//   rst       asynchronous active-high reset
//   en        start request, sampled only while idle
//   bcd_d_in  packed BCD operand, digit 0 in [3:0]
//   bin_out   converted value, held until the next successful conversion
//   rdy       one-cycle completion pulse
//   err       invalid-digit flag, meaningful only while rdy=1
//   busy      high while a conversion is in flight (CONV and DONE)
module bcd_to_bin_seq #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned CW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd_d_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  rdy,
  output logic                  err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [4*DIGITS-1:0]       r_bcd;
  logic [BIN_W-1:0]          r_bin;
  logic [CW-1:0]             r_cnt;
  logic [BIN_W-1:0]          r_bin_out;
  logic                      r_rdy;
  logic                      r_err;

  logic                      w_valid;
  logic                      w_load;
  logic                      w_reject;
  logic [4*DIGITS+BIN_W-1:0] w_cat;
  logic [4*DIGITS-1:0]       w_bcd_step;
  logic [BIN_W-1:0]          w_bin_step;

  // Operand is accepted only if every nibble is a decimal digit.
  always_comb begin
    w_valid = 1'b1;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_d_in[4*d +: 4] > 4'd9) w_valid = 1'b0;
    end
  end

  // One reverse double-dabble iteration: shift, then correct digits >= 8
  // (digit MSB set) by subtracting 3.
  always_comb begin
    w_cat      = {r_bcd, r_bin} >> 1;
    w_bin_step = w_cat[BIN_W-1:0];
    w_bcd_step = w_cat[4*DIGITS+BIN_W-1 -: 4*DIGITS];
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (w_bcd_step[4*d+3]) w_bcd_step[4*d +: 4] = w_bcd_step[4*d +: 4] - 4'd3;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          if (w_valid) begin
            w_load      = 1'b1;
            w_state_nxt = CONV;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      CONV: begin
        if (r_cnt == CW'(BIN_W - 1)) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_bin_out <= '0;
      r_rdy     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_bcd <= bcd_d_in;
            r_bin <= '0;
            r_cnt <= '0;
          end
          if (w_reject) begin
            r_rdy <= 1'b1;
            r_err <= 1'b1;
          end
        end
        CONV: begin
          r_bcd <= w_bcd_step;
          r_bin <= w_bin_step;
          r_cnt <= r_cnt + CW'(1);
        end
        DONE: begin
          r_bin_out <= r_bin;
          r_rdy     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bin_out = r_bin_out;
  assign rdy     = r_rdy;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule
